// File: rtl/decode_queue.sv
// Instruction queue between fetch and ID: each word is decoded as it is enqueued,
// and the outputs present the stored decode of the oldest entry (a NOP bubble when empty).
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int M_EXT = 0
) (
    input  logic                       CPU_CLK,
    input  logic                       CPU_RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic                       out_jal,
    output logic                       out_jalr,
    output logic [2:0]                 out_regwrite,
    output logic                       out_memtoreg,
    output logic [3:0]                 out_memwrite,
    output logic                       out_loadnpc,
    output logic [1:0]                 out_regread,
    output logic [2:0]                 out_branchtype,
    output logic [3:0]                 out_aluctrl,
    output logic [1:0]                 out_alusrc2,
    output logic                       out_alusrc1,
    output logic [2:0]                 out_immtype,
    output logic                       out_md,
    output logic [2:0]                 out_mdop,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [2:0] RW_LB = 3'd1, RW_LH = 3'd2, RW_LW = 3'd3, RW_LBU = 3'd4, RW_LHU = 3'd5;
    localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3, BR_BLTU = 3'd4,
                           BR_BGE = 3'd5, BR_BGEU = 3'd6;
    localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
                           IMM_U = 3'd4, IMM_J = 3'd5;
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3,
                           ALU_SUB = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;
    localparam logic [1:0] SRC2_REG = 2'd0, SRC2_SHAMT = 2'd1, SRC2_IMM = 2'd2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic [2:0] regwrite;
        logic       memtoreg;
        logic [3:0] memwrite;
        logic       loadnpc;
        logic [1:0] regread;
        logic [2:0] branchtype;
        logic [3:0] aluctrl;
        logic [1:0] alusrc2;
        logic       alusrc1;
        logic [2:0] immtype;
        logic       md;
        logic [2:0] mdop;
        logic       illegal;
    } ctrl_t;

    ctrl_t       ctrl_mem [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic        push, pop;
    ctrl_t       raw, dec, out_ctrl;
    logic        bad;
    logic [6:0]  opcode, fn7;
    logic [2:0]  fn3;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    assign opcode = in_instr[6:0];
    assign fn3    = in_instr[14:12];
    assign fn7    = in_instr[31:25];

    always_comb begin
        raw = '0;
        bad = 1'b0;
        case (opcode)
            OPC_LUI: begin
                raw.regwrite = RW_LW; raw.aluctrl = ALU_LUI; raw.alusrc2 = SRC2_IMM; raw.immtype = IMM_U;
            end
            OPC_AUIPC: begin
                raw.regwrite = RW_LW; raw.aluctrl = ALU_ADD; raw.alusrc2 = SRC2_IMM;
                raw.alusrc1 = 1'b1; raw.immtype = IMM_U;
            end
            OPC_JAL: begin
                raw.jal = 1'b1; raw.regwrite = RW_LW; raw.loadnpc = 1'b1; raw.aluctrl = ALU_ADD;
                raw.alusrc2 = SRC2_IMM; raw.alusrc1 = 1'b1; raw.immtype = IMM_J;
            end
            OPC_JALR: begin
                raw.jalr = 1'b1; raw.regwrite = RW_LW; raw.loadnpc = 1'b1; raw.regread = 2'b10;
                raw.aluctrl = ALU_ADD; raw.alusrc2 = SRC2_IMM; raw.immtype = IMM_I;
                bad = (fn3 != 3'b000);
            end
            OPC_BRANCH: begin
                raw.regread = 2'b11; raw.immtype = IMM_B;
                case (fn3)
                    3'b000:  raw.branchtype = BR_BEQ;
                    3'b001:  raw.branchtype = BR_BNE;
                    3'b100:  raw.branchtype = BR_BLT;
                    3'b101:  raw.branchtype = BR_BGE;
                    3'b110:  raw.branchtype = BR_BLTU;
                    3'b111:  raw.branchtype = BR_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                raw.memtoreg = 1'b1; raw.regread = 2'b10; raw.aluctrl = ALU_ADD;
                raw.alusrc2 = SRC2_IMM; raw.immtype = IMM_I;
                case (fn3)
                    3'b000:  raw.regwrite = RW_LB;
                    3'b001:  raw.regwrite = RW_LH;
                    3'b010:  raw.regwrite = RW_LW;
                    3'b100:  raw.regwrite = RW_LBU;
                    3'b101:  raw.regwrite = RW_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                raw.regread = 2'b11; raw.aluctrl = ALU_ADD; raw.alusrc2 = SRC2_IMM; raw.immtype = IMM_S;
                case (fn3)
                    3'b000:  raw.memwrite = 4'b0001;
                    3'b001:  raw.memwrite = 4'b0011;
                    3'b010:  raw.memwrite = 4'b1111;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                raw.regwrite = RW_LW; raw.regread = 2'b10; raw.immtype = IMM_I; raw.alusrc2 = SRC2_IMM;
                raw.aluctrl = alu_sel(fn3, fn7[5] && (fn3 == 3'b101));
                // Shift-immediates carry their variant in the upper immediate bits.
                if (fn3 == 3'b001) begin
                    raw.alusrc2 = SRC2_SHAMT;
                    bad = (fn7 != 7'b0000000);
                end else if (fn3 == 3'b101) begin
                    raw.alusrc2 = SRC2_SHAMT;
                    bad = (fn7 != 7'b0000000) && (fn7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                raw.regwrite = RW_LW; raw.regread = 2'b11; raw.immtype = IMM_R; raw.alusrc2 = SRC2_REG;
                if (fn7 == 7'b0000000) begin
                    raw.aluctrl = alu_sel(fn3, 1'b0);
                end else if (fn7 == 7'b0100000) begin
                    raw.aluctrl = alu_sel(fn3, 1'b1);
                    bad = (fn3 != 3'b000) && (fn3 != 3'b101);
                end else if (fn7 == 7'b0000001 && M_EXT != 0) begin
                    raw.md = 1'b1; raw.mdop = fn3; raw.aluctrl = 4'd0;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        dec = raw;
        if (bad) begin
            dec = '0;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge CPU_CLK) begin
        if (push) begin
            ctrl_mem[wr_ptr]  <= dec;
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 32'h0;

    assign out_jal        = out_ctrl.jal;
    assign out_jalr       = out_ctrl.jalr;
    assign out_regwrite   = out_ctrl.regwrite;
    assign out_memtoreg   = out_ctrl.memtoreg;
    assign out_memwrite   = out_ctrl.memwrite;
    assign out_loadnpc    = out_ctrl.loadnpc;
    assign out_regread    = out_ctrl.regread;
    assign out_branchtype = out_ctrl.branchtype;
    assign out_aluctrl    = out_ctrl.aluctrl;
    assign out_alusrc2    = out_ctrl.alusrc2;
    assign out_alusrc1    = out_ctrl.alusrc1;
    assign out_immtype    = out_ctrl.immtype;
    assign out_md         = out_ctrl.md;
    assign out_mdop       = out_ctrl.mdop;
    assign out_illegal    = out_ctrl.illegal;

endmodule
